// File: rtl/div_pkg.sv
// div_pkg: shared widths, state encoding and divide-by-zero result constants for div16x8_seq
package div_pkg;
  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  localparam int CNT_W = $clog2(DW_DEF);
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam logic [DW_DEF-1:0] DZ_QUO = '1;
  localparam logic [VW_DEF-1:0] DZ_REM = '1;
endpackage

// File: rtl/div16x8_seq_if.sv
// div16x8_seq_if: divider request/result bundle
//   master drives start/dividend/divisor; slave (the divider) drives busy/done/quotient/remainder/div_by_zero
interface div16x8_seq_if #(parameter int DW = 16, parameter int VW = 8);
  logic start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic busy;
  logic done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
//   part_in (VW+1) and bit_in form the shifted partial; part_out/q_bit are the step result
module div_step #(parameter int VW = 8) (
  input  logic [VW:0]   part_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   part_out,
  output logic          q_bit
);
  logic [VW:0] shifted;
  // The incoming partial is always below the divisor, so its top bit is zero and may be dropped.
  assign shifted = {part_in[VW-1:0], bit_in};
  assign q_bit = shifted >= {1'b0, divisor};
  assign part_out = q_bit ? shifted - {1'b0, divisor} : shifted;
endmodule

// File: rtl/div16x8_seq.sv
// div16x8_seq: sequential restoring divider, one quotient bit per clock
//   clk, rst (async, active-high); bus: slave side of div16x8_seq_if
module div16x8_seq import div_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input logic clk,
  input logic rst,
  div16x8_seq_if.slave bus
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dq_q, dq_d;
  logic [VW:0] part_q, part_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW:0] part_nx;
  logic q_bit, last, zero;
  div_step #(.VW(VW)) u_step (
    .part_in(part_q),
    .bit_in(dq_q[DW-1]),
    .divisor(dvs_q),
    .part_out(part_nx),
    .q_bit(q_bit)
  );
  assign last = cnt_q == CNT_W'(DW-1);
  assign zero = dvs_q == '0;
  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dq_d = dq_q;
    part_d = part_q;
    dvs_d = dvs_q;
    busy_d = busy_q;
    done_d = 1'b0;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d = dz_q;
    if (state_q == ST_IDLE) begin
      if (bus.start) begin
        state_d = ST_RUN;
        cnt_d = '0;
        dq_d = bus.dividend;
        dvs_d = bus.divisor;
        part_d = '0;
        busy_d = 1'b1;
        dz_d = 1'b0;
      end
    end else begin
      part_d = part_nx;
      dq_d = {dq_q[DW-2:0], q_bit};
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = ST_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        quo_d = zero ? DW'(DZ_QUO) : {dq_q[DW-2:0], q_bit};
        rem_d = zero ? VW'(DZ_REM) : part_nx[VW-1:0];
        dz_d = zero;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      dq_q <= '0;
      part_q <= '0;
      dvs_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dq_q <= dq_d;
      part_q <= part_d;
      dvs_q <= dvs_d;
      busy_q <= busy_d;
      done_q <= done_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quotient = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_div16x8_seq.sv
// tb_div16x8_seq: directed self-checking bench for div16x8_seq
module tb_div16x8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int n;
  div16x8_seq_if #(.DW(16), .VW(8)) bus ();
  div16x8_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(inout int cnt);
    while (bus.done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic result(input string tag, input logic [15:0] q, input logic [7:0] r, input logic dz);
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_q"}, bus.quotient, q);
    chk({tag, "_r"}, bus.remainder, r);
    chk({tag, "_dz"}, bus.div_by_zero, dz);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    go(16'd100, 8'd7);
    chk("busy_e0", bus.busy, 1);
    chk("hold_q_e0", bus.quotient, 0);
    n = 0;
    wait_done(n);
    result("d100_7", 16'd14, 8'd2, 1'b0);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("hold_q", bus.quotient, 14);
    go(16'hFFFF, 8'd255);
    n = 0;
    wait_done(n);
    result("ffff_255", 16'd257, 8'd0, 1'b0);
    go(16'hFE01, 8'd255);
    n = 0;
    wait_done(n);
    result("fe01_255", 16'd255, 8'd0, 1'b0);
    go(16'd1234, 8'd0);
    n = 0;
    wait_done(n);
    result("dz", 16'hFFFF, 8'hFF, 1'b1);
    go(16'd10, 8'd3);
    chk("dz_clear_e0", bus.div_by_zero, 0);
    chk("dz_hold_q", bus.quotient, 16'hFFFF);
    n = 0;
    wait_done(n);
    result("d10_3", 16'd3, 8'd1, 1'b0);
    go(16'd50, 8'd5);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b1;
    bus.dividend = 16'd99;
    bus.divisor = 8'd9;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    wait_done(n);
    result("ignored", 16'd10, 8'd0, 1'b0);
    bus.start = 1'b1;
    bus.dividend = 16'd99;
    bus.divisor = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done", bus.done, 0);
    n = 0;
    wait_done(n);
    result("b2b", 16'd11, 8'd0, 1'b0);
    go(16'd500, 8'd3);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_q", bus.quotient, 0);
    chk("arst_r", bus.remainder, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_dz", bus.div_by_zero, 0);
    repeat (12) @(negedge clk);
    chk("arst_nodone", bus.done, 0);
    rst = 1'b0;
    go(16'd500, 8'd3);
    n = 0;
    wait_done(n);
    result("d500_3", 16'd166, 8'd2, 1'b0);
    for (int a = 0; a < 256; a += 17) begin
      for (int b = 1; b < 256; b += 14) begin
        go(16'(a * b), 8'(b));
        n = 0;
        wait_done(n);
        chk("xq", bus.quotient, 32'(a));
        chk("xr", bus.remainder, 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
